// File: rtl/sram_wr_arbiter.sv
// Round-robin arbiter sharing one SRAM write port among NUM_REQ valid/ready requesters.
// Define SRAM_WR_ARB_INIT_EN to add a post-reset sweep writing INIT_VALUE to every entry.
module sram_wr_arbiter #(
  parameter int unsigned SRAM_DEPTH = 64,
  parameter int unsigned SRAM_INDEX = 6,
  parameter int unsigned SRAM_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [SRAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0] req_addr_i,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          we_o,
  output logic [SRAM_INDEX-1:0]         addrWr_o,
  output logic [SRAM_WIDTH-1:0]         data_o,
  output logic [2:0]                    grant_id_o,
  output logic                          busy_o
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || SRAM_DEPTH > (2 ** SRAM_INDEX) ||
      $bits(INIT_VALUE) != SRAM_WIDTH) begin : g_bad_cfg
    $error("sram_wr_arbiter: unsupported parameter set");
  end

  logic                  we_q;
  logic [SRAM_INDEX-1:0] addr_q;
  logic [SRAM_WIDTH-1:0] data_q;
  logic [2:0]            gid_q;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;
  logic                  run_en;

  logic                  found;
  logic                  hs;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         scan_idx;
  int unsigned           scan;
  logic [SRAM_INDEX-1:0] addr_sel;
  logic [SRAM_WIDTH-1:0] data_sel;

`ifdef SRAM_WR_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t                state_q;
  logic [SRAM_INDEX-1:0] init_cnt_q;
  logic                  busy_q;

  // busy_q lags the state by one cycle so it covers every sweep write on the port
  assign run_en = ~busy_q;
  assign busy_o = busy_q;
`else
  assign run_en = 1'b1;
  assign busy_o = 1'b0;
`endif

  always_comb begin
    win_idx  = '0;
    found    = 1'b0;
    scan     = 0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = 32'(ptr_q) + i;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_idx = PW'(scan);
      if (!found && req_valid_i[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign hs          = run_en & found;
  assign req_ready_o = hs ? (NUM_REQ'(1) << win_idx) : '0;
  assign ptr_d       = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == win_idx) begin
        addr_sel = req_addr_i[i*SRAM_INDEX +: SRAM_INDEX];
        data_sel = req_data_i[i*SRAM_WIDTH +: SRAM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
      ptr_q  <= '0;
`ifdef SRAM_WR_ARB_INIT_EN
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      busy_q     <= 1'b1;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef SRAM_WR_ARB_INIT_EN
      busy_q <= (state_q == ST_INIT);
      case (state_q)
        ST_INIT: begin
          we_q       <= 1'b1;
          addr_q     <= init_cnt_q;
          data_q     <= INIT_VALUE;
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == SRAM_INDEX'(SRAM_DEPTH - 1)) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
`endif
      if (hs) begin
        we_q   <= 1'b1;
        addr_q <= addr_sel;
        data_q <= data_sel;
        gid_q  <= 3'(win_idx);
        ptr_q  <= ptr_d;
      end
    end
  end

  assign we_o       = we_q;
  assign addrWr_o   = addr_q;
  assign data_o     = data_q;
  assign grant_id_o = gid_q;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Self-checking bench for sram_wr_arbiter: vector table plus hand sequences, with a
// queue of expected SRAM writes checked one cycle after each handshake.
module tb_sram_wr_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              we;
  logic [AW-1:0]     addr_wr;
  logic [DW-1:0]     data_wr;
  logic [2:0]        grant_id;
  logic              busy;

  logic [AW-1:0] a_arr [NR];
  logic [DW-1:0] d_arr [NR];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    id;
  } wr_t;

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  hold;
  int   n_cmp = 0;
  int   n_err = 0;
  int   seq [NR];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      req_addr[k*AW +: AW] = a_arr[k];
      req_data[k*DW +: DW] = d_arr[k];
    end
  end

  sram_wr_arbiter #(.SRAM_DEPTH(64), .SRAM_INDEX(AW), .SRAM_WIDTH(DW), .NUM_REQ(NR),
                    .INIT_VALUE('0)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(req_ready), .we_o(we), .addrWr_o(addr_wr),
    .data_o(data_wr), .grant_id_o(grant_id), .busy_o(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_write();
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we", 32'(we), 32'd1);
      chk("addr", 32'(addr_wr), 32'(e.a));
      chk("data", data_wr, e.d);
      chk("grant_id", 32'(grant_id), 32'(e.id));
      hold = e;
    end else begin
      chk("we_idle", 32'(we), 32'd0);
      chk("addr_hold", 32'(addr_wr), 32'(hold.a));
      chk("data_hold", data_wr, hold.d);
      chk("gid_hold", 32'(grant_id), 32'(hold.id));
    end
  endtask

  // One RUN-mode cycle: check ready and the port, then queue the write this cycle grants.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] er);
    req_valid = v;
    @(negedge clk);
    chk("ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'd0);
    chk_write();
    for (int k = 0; k < NR; k++)
      if (er[k]) exp_q.push_back('{a: a_arr[k], d: d_arr[k], id: 3'(k)});
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [NR-1:0] v);
    reset = 1'b1;
    req_valid = v;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    hold = '0;
    reset = 1'b0;
  endtask

  // Sweep check from the first cycle after reset release; stops early at stop_addr.
  task automatic init_sweep(input int stop_addr);
`ifdef SRAM_WR_ARB_INIT_EN
    @(negedge clk);
    chk("init_c0_we", 32'(we), 32'd0);
    chk("init_c0_busy", 32'(busy), 32'd1);
    chk("init_c0_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("init_we", 32'(we), 32'd1);
      chk("init_addr", 32'(addr_wr), 32'(i));
      chk("init_data", data_wr, 32'd0);
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_ready", 32'(req_ready), 32'd0);
      if (i == stop_addr) return;
    end
    @(posedge clk); #1;
    hold = '{a: 6'd63, d: '0, id: 3'd0};
`else
    if (stop_addr < 0) hold = '0;
`endif
  endtask

  vec_t vt [];

  initial begin
    vt = new[22];
    vt[0]  = '{4'b1000, 4'b1000};
    vt[1]  = '{4'b1111, 4'b0001};
    vt[2]  = '{4'b1111, 4'b0010};
    vt[3]  = '{4'b1111, 4'b0100};
    vt[4]  = '{4'b1111, 4'b1000};
    vt[5]  = '{4'b1111, 4'b0001};
    vt[6]  = '{4'b1111, 4'b0010};
    vt[7]  = '{4'b1111, 4'b0100};
    vt[8]  = '{4'b1111, 4'b1000};
    vt[9]  = '{4'b0110, 4'b0010};
    vt[10] = '{4'b0110, 4'b0100};
    vt[11] = '{4'b0011, 4'b0001};
    vt[12] = '{4'b1001, 4'b1000};
    vt[13] = '{4'b0000, 4'b0000};
    vt[14] = '{4'b1000, 4'b1000};
    vt[15] = '{4'b0010, 4'b0010};
    vt[16] = '{4'b0001, 4'b0001};
    vt[17] = '{4'b1100, 4'b0100};
    vt[18] = '{4'b1100, 4'b1000};
    vt[19] = '{4'b0101, 4'b0001};
    vt[20] = '{4'b0101, 4'b0100};
    vt[21] = '{4'b0011, 4'b0001};

    for (int k = 0; k < NR; k++) begin
      a_arr[k] = '0; d_arr[k] = '0; seq[k] = 0;
    end

    // Requester 1 held valid through reset: granted in the first RUN cycle.
    a_arr[1] = 6'h07; d_arr[1] = 32'h1111_0001;
    do_reset(4'b0010);
`ifdef SRAM_WR_ARB_INIT_EN
    init_sweep(-1);
`endif
    step(4'b0010, 4'b0010);               // ptr -> 2
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);               // hold values after idle

    // Single requester with fixed address/data, ptr 2 -> 3
    a_arr[2] = 6'h15; d_arr[2] = 32'hDEAD_BEEF;
    step(4'b0100, 4'b0100);
    // Wrap and skip from ptr 3
    a_arr[0] = 6'h01; d_arr[0] = 32'hA000_0000;
    a_arr[2] = 6'h22; d_arr[2] = 32'hA000_0002;
    step(4'b0101, 4'b0001);
    step(4'b0101, 4'b0100);               // ptr -> 3

    // Same address from requesters 0 and 3 (ptr 3): 3 writes first, then 0.
    a_arr[0] = 6'h2A; d_arr[0] = 32'h0000_AAAA;
    a_arr[3] = 6'h2A; d_arr[3] = 32'h3333_BBBB;
    step(4'b1001, 4'b1000);
    step(4'b0001, 4'b0001);               // ptr -> 1
    step(4'b0010, 4'b0010);               // ptr -> 2
    step(4'b0100, 4'b0100);               // ptr -> 3, table starts at ptr 3
    step(4'b0000, 4'b0000);

    foreach (vt[r]) begin
      for (int k = 0; k < NR; k++) begin
        a_arr[k] = AW'(k * 16 + seq[k]);
        d_arr[k] = {8'(8'hC0 + k), 24'(seq[k])};
      end
      step(vt[r].valid, vt[r].exp_ready);
      for (int k = 0; k < NR; k++) if (vt[r].exp_ready[k]) seq[k]++;
    end
    step(4'b0000, 4'b0000);

    // Handshake in the same cycle reset is asserted: no write emerges.
    a_arr[2] = 6'h3C; d_arr[2] = 32'h5555_5555;
    req_valid = 4'b0100;
    reset = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("rst_drop_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr_wr), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    do_reset(4'b0000);
`ifdef SRAM_WR_ARB_INIT_EN
    init_sweep(32);
    reset = 1'b1;                         // sampled at the edge ending this cycle
    @(negedge clk);
    chk("midsweep_we0", 32'(we), 32'd0);
    @(negedge clk);
    chk("midsweep_we1", 32'(we), 32'd0);
    chk("midsweep_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b0;
    init_sweep(-1);
`endif
    // ptr back at 0 after reset
    a_arr[3] = 6'h33; d_arr[3] = 32'h0BAD_F00D;
    step(4'b1111, 4'b0001);
    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
